dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 86 ++++++++
 tb/tb_dmem_responder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word load/store responder with access latency and error flagging (optional DMEM_ERR_CHECK_EN)
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int DEPTH_BYTES = 2 ** ADDR_W;
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t state, next_state;
    logic [31:0] mem [DEPTH_BYTES / 4];
    logic [CNT_W-1:0] cnt;
    logic [ADDR_W-3:0] l_idx;
    logic [31:0] l_wdata;
    logic l_we, l_err, err_in, accept, leave;

`ifdef DMEM_ERR_CHECK_EN
    assign err_in = (req_addr[1:0] != 2'b0) || (req_addr[31:ADDR_W] != '0);
`else
    logic unused_addr_bits;
    assign err_in = 1'b0;
    assign unused_addr_bits = ^{req_addr[31:ADDR_W], req_addr[1:0]};
`endif

    assign accept = req_valid && req_ready;
    // WAIT spans LATENCY+1 cycles so the response appears LATENCY+1 edges after acceptance
    assign leave = (state == ST_WAIT) && (cnt == CNT_W'(LATENCY));

    // state register
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= ST_IDLE;
        else state <= next_state;

    // next-state logic
    always_comb
        next_state = (state == ST_IDLE && accept) ? ST_WAIT :
                     leave ? ST_RESP :
                     (state == ST_RESP && rsp_ready) ? ST_IDLE : state;

    // handshake outputs; ready is forced low while reset is held
    always_comb begin
        req_ready = reset_n && (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
    end

    // request latch, wait counter and response registers
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            cnt       <= '0;
            l_we      <= 1'b0;
            l_err     <= 1'b0;
            l_idx     <= '0;
            l_wdata   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                l_we    <= req_we;
                l_err   <= err_in;
                l_idx   <= req_addr[ADDR_W-1:2];
                l_wdata <= req_wdata;
                cnt     <= '0;
            end else if (state == ST_WAIT && !leave) cnt <= cnt + 1'b1;
            if (leave) begin
                rsp_rdata <= (l_we || l_err) ? 32'h0 : mem[l_idx];
                rsp_err   <= l_err;
            end else if (rsp_valid && rsp_ready) rsp_err <= 1'b0;
        end

    // storage is not reset; stores commit on the edge leaving WAIT
    always_ff @(posedge clock)
        if (leave && l_we && !l_err) mem[l_idx] <= l_wdata;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder at LATENCY 2 and 0
module tb_dmem_responder;
`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clock = 1'b0, reset_n = 1'b0, sel = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic a_ready, a_valid, a_err, b_ready, b_valid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic cur_ready, cur_valid, cur_err;
    logic [31:0] cur_rdata, held;
    int n_cmp = 0, n_bad = 0, lat, hs;

    always #5 clock = ~clock;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut_a (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid && !sel), .req_ready(a_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(a_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(a_rdata), .rsp_err(a_err));

    dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid && sel), .req_ready(b_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(b_rdata), .rsp_err(b_err));

    assign cur_ready = sel ? b_ready : a_ready;
    assign cur_valid = sel ? b_valid : a_valid;
    assign cur_err   = sel ? b_err   : a_err;
    assign cur_rdata = sel ? b_rdata : a_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
        int t;
        req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1; t = 0;
        while (!cur_ready && t < 20) begin tick(); t++; end
        chk("accept_bound", 32'(t < 20), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int l);
        l = 0;
        while (!cur_valid && l < 20) begin tick(); l++; end
    endtask

    task automatic handshake;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input string tag, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        issue(we, a, d);
        wait_rsp(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, cur_rdata, exp_rdata);
        chk({tag, "_err"}, 32'(cur_err), 32'(exp_err));
        handshake();
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_err", 32'(a_err), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(a_ready), 32'd1);

        xact("st10", 1'b1, 32'h10, 32'h12345678, 3, 32'h0, 1'b0);
        xact("ld10", 1'b0, 32'h10, 32'h0, 3, 32'h12345678, 1'b0);

        issue(1'b0, 32'h10, 32'h0);
        wait_rsp(lat);
        chk("bp_lat", 32'(lat), 32'd3);
        held = cur_rdata;
        chk("bp_rdata", held, 32'h12345678);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(a_valid), 32'd1);
            chk("bp_hold_rdata", a_rdata, held);
            chk("bp_hold_ready", 32'(a_ready), 32'd0);
        end
        handshake();
        chk("bp_after_valid", 32'(a_valid), 32'd0);
        chk("bp_after_ready", 32'(a_ready), 32'd1);
        chk("bp_after_rdata", a_rdata, 32'h12345678);
        wait_rsp(lat);
        chk("bp_second_lat", 32'(lat), 32'd4);
        chk("bp_second_rdata", a_rdata, 32'h12345678);
        handshake();

        xact("st20", 1'b1, 32'h20, 32'hCAFEF00D, 3, 32'h0, 1'b0);
        xact("mis21", 1'b1, 32'h21, 32'hFFFFFFFF, 3, 32'h0, ERR);
        chk("mis_err_clear", 32'(a_err), 32'd0);
        xact("ld20", 1'b0, 32'h20, 32'h0, 3, ERR ? 32'hCAFEF00D : 32'hFFFFFFFF, 1'b0);

        xact("st00", 1'b1, 32'h0, 32'h0BADBEEF, 3, 32'h0, 1'b0);
        xact("ld400", 1'b0, 32'h400, 32'h0, 3, ERR ? 32'h0 : 32'h0BADBEEF, ERR);
        chk("oor_err_clear", 32'(a_err), 32'd0);

        xact("st40", 1'b1, 32'h40, 32'h0, 3, 32'h0, 1'b0);
        issue(1'b1, 32'h40, 32'hAAAA5555);
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(a_valid), 32'd0);
        chk("midrst_ready", 32'(a_ready), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        xact("ld40", 1'b0, 32'h40, 32'h0, 3, 32'h0, 1'b0);
        xact("ld10_kept", 1'b0, 32'h10, 32'h0, 3, 32'h12345678, 1'b0);

        sel = 1'b1;
        xact("b_st10", 1'b1, 32'h10, 32'h11223344, 1, 32'h0, 1'b0);
        xact("b_ld10", 1'b0, 32'h10, 32'h0, 1, 32'h11223344, 1'b0);
        chk("b_idle_ready", 32'(b_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; rsp_ready = 1'b1; hs = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (b_valid) begin
                hs++;
                chk("b_tput_rdata", b_rdata, 32'h11223344);
            end
        end
        chk("b_tput_count", 32'(hs), 32'd3);
        req_valid = 1'b0; rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
